// File: rtl/cbus_line_master.sv
// cbus_line_master: turns a whole-cache-line request into one CBus INCR burst
// of LINE_WORDS 64-bit beats. It handles refills (reads) and writebacks (writes).
//
// Ports
//   clk, reset        : single clock; asynchronous active-low reset
//   creq_*            : line request from the cache (valid/ready handshake)
//   cresp_valid       : one-cycle completion pulse
//   cresp_err         : qualifies cresp_valid, 1 = watchdog abort
//   cresp_rline       : refill data, held until the next accepted request
//   oreq / oresp      : CBus request / response (cbus_pkg types)
//
// Build option
//   CBUS_LINE_MASTER_TIMEOUT_EN : enables a burst watchdog of TIMEOUT_CYCLES.
//   When it is not defined, cresp_err is tied low and a burst waits forever.

package cbus_pkg;
    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [7:0]  len;
        msize_t      size;
        axi_burst_t  burst;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_line_master
    import cbus_pkg::*;
#(
    parameter int unsigned LINE_WORDS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     creq_valid,
    output logic                     creq_ready,
    input  logic                     creq_write,
    input  logic [63:0]              creq_addr,
    input  logic [LINE_WORDS*64-1:0] creq_wline,
    output logic                     cresp_valid,
    output logic [LINE_WORDS*64-1:0] cresp_rline,
    output logic                     cresp_err,
    output cbus_req_t                oreq,
    input  cbus_resp_t               oresp
);
    localparam int unsigned       OFS_W     = $clog2(LINE_WORDS) + 3;
    localparam int unsigned       BEAT_W    = $clog2(LINE_WORDS) + 1;
    localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(LINE_WORDS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t                  state_q, state_d;
    logic [63:0]             addr_q;
    logic                    write_q;
    logic [LINE_WORDS*64-1:0] wline_q;
    logic [LINE_WORDS*64-1:0] rline_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [BEAT_W-1:0]       widx;
    logic [63:0]             wdata;
    logic                    accept;
    logic                    beat_done;
    logic                    timeout_hit;

    assign accept    = (state_q == IDLE) && creq_valid;
    assign beat_done = (state_q == BURST) && oresp.ready;

`ifdef CBUS_LINE_MASTER_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES,
    // so DONE lands exactly TIMEOUT_CYCLES cycles after entering BURST.
    assign timeout_hit = (state_q == BURST) && !oresp.ready &&
                         (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept || beat_done) begin
                wd_q <= '0;
            end else if (state_q == BURST) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (state_q == BURST) begin
                err_q <= timeout_hit;
            end
        end
    end

    assign cresp_err = (state_q == DONE) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign cresp_err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (creq_valid) state_d = BURST;
            BURST:   if ((oresp.ready && oresp.last) || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, beat counter and refill buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wline_q <= '0;
            rline_q <= '0;
            beat_q  <= '0;
        end else if (accept) begin
            addr_q  <= {creq_addr[63:OFS_W], {OFS_W{1'b0}}};
            write_q <= creq_write;
            wline_q <= creq_wline;
            beat_q  <= '0;
        end else if (beat_done && (beat_q != BEAT_END)) begin
            // Beats past the end of the line are dropped; the counter saturates.
            if (!write_q) begin
                for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                    if (beat_q == BEAT_W'(i)) begin
                        rline_q[i*64 +: 64] <= oresp.data;
                    end
                end
            end
            beat_q <= beat_q + BEAT_W'(1);
        end
    end

    assign widx        = (beat_q == BEAT_END) ? BEAT_LAST : beat_q;
    assign cresp_rline = rline_q;

    // Output logic
    always_comb begin
        wdata = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (widx == BEAT_W'(i)) begin
                wdata = wline_q[i*64 +: 64];
            end
        end

        oreq        = '0;
        creq_ready  = (state_q == IDLE);
        cresp_valid = (state_q == DONE);

        if (state_q == BURST) begin
            oreq.valid    = 1'b1;
            oreq.is_write = write_q;
            oreq.addr     = addr_q;
            oreq.len      = 8'(LINE_WORDS - 1);
            oreq.size     = MSIZE8;
            oreq.burst    = AXI_BURST_INCR;
            if (write_q) begin
                oreq.data   = wdata;
                oreq.strobe = 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_cbus_line_master.sv
// Self-checking bench for cbus_line_master (LINE_WORDS=4, TIMEOUT_CYCLES=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_cbus_line_master;
    import cbus_pkg::*;

    typedef struct packed {
        logic           write;
        logic [63:0]    addr;
        logic [255:0]   wline;
        logic [5:0][63:0] rdata;
        logic [3:0]     last_beat;
        logic [63:0]    exp_addr;
        logic [255:0]   exp_rline;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         creq_valid;
    logic         creq_ready;
    logic         creq_write;
    logic [63:0]  creq_addr;
    logic [255:0] creq_wline;
    logic         cresp_valid;
    logic [255:0] cresp_rline;
    logic         cresp_err;
    cbus_req_t    oreq;
    cbus_resp_t   oresp;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_id   = -1;

    vec_t vecs [6];

    cbus_line_master #(
        .LINE_WORDS(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .creq_valid(creq_valid),
        .creq_ready(creq_ready),
        .creq_write(creq_write),
        .creq_addr(creq_addr),
        .creq_wline(creq_wline),
        .cresp_valid(cresp_valid),
        .cresp_rline(cresp_rline),
        .cresp_err(cresp_err),
        .oreq(oreq),
        .oresp(oresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk1(input string n, input logic a, input logic e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s (seq %0d): actual %0b required %0b", n, cur_id, a, e);
        end
    endtask

    task automatic chk64(input string n, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s (seq %0d): actual %0h required %0h", n, cur_id, a, e);
        end
    endtask

    task automatic chk256(input string n, input logic [255:0] a, input logic [255:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s (seq %0d): actual %0h required %0h", n, cur_id, a, e);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [63:0] a, input logic [255:0] wl,
                                input logic [383:0] rd, input logic [3:0] lb,
                                input logic [63:0] ea, input logic [255:0] er);
        vec_t v;
        v.write     = w;
        v.addr      = a;
        v.wline     = wl;
        v.rdata     = rd;
        v.last_beat = lb;
        v.exp_addr  = ea;
        v.exp_rline = er;
        return v;
    endfunction

    // One full transaction with an always-ready responder; starts and ends at
    // posedge+1 with the DUT in IDLE.
    task automatic do_txn(input vec_t v);
        logic [63:0] exp_d;
        int          wi;
        creq_valid = 1'b1;
        creq_write = v.write;
        creq_addr  = v.addr;
        creq_wline = v.wline;
        oresp      = '0;
        @(negedge clk);
        chk1("idle_ready", creq_ready, 1'b1);
        @(posedge clk); #1;
        creq_valid = 1'b0;
        creq_addr  = '1;
        creq_wline = '0;
        for (int b = 0; b <= int'(v.last_beat); b++) begin
            oresp.ready = 1'b1;
            oresp.last  = (b == int'(v.last_beat));
            oresp.data  = v.rdata[b];
            wi    = (b > 3) ? 3 : b;
            exp_d = v.write ? v.wline[wi*64 +: 64] : 64'd0;
            @(negedge clk);
            chk1("oreq_valid", oreq.valid, 1'b1);
            chk64("oreq_addr", oreq.addr, v.exp_addr);
            chk64("oreq_len", 64'(oreq.len), 64'd3);
            chk64("oreq_size", 64'(oreq.size), 64'(MSIZE8));
            chk64("oreq_burst", 64'(oreq.burst), 64'(AXI_BURST_INCR));
            chk1("oreq_is_write", oreq.is_write, v.write);
            chk64("oreq_strobe", 64'(oreq.strobe), v.write ? 64'hFF : 64'h0);
            chk64("oreq_data", oreq.data, exp_d);
            chk1("busy_no_resp", cresp_valid, 1'b0);
            chk1("busy_not_ready", creq_ready, 1'b0);
            @(posedge clk); #1;
        end
        oresp = '0;
        @(negedge clk);
        chk1("done_valid", cresp_valid, 1'b1);
        chk1("done_err", cresp_err, 1'b0);
        chk256("done_rline", cresp_rline, v.exp_rline);
        chk1("done_oreq_idle", oreq.valid, 1'b0);
        chk1("done_not_ready", creq_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("after_pulse", cresp_valid, 1'b0);
        chk1("after_ready", creq_ready, 1'b1);
        chk256("rline_hold", cresp_rline, v.exp_rline);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] aw [4];
        logic [1:0]  exp_rdy;
        logic [6:0]  exp_ready_pat;
        logic [6:0]  exp_cv_pat;
        int          beats;
        int          dones;

        vecs[0] = mk(1'b0, 64'h0000_0000_8000_0040, '0,
                     {64'h0, 64'h0, 64'h44, 64'h33, 64'h22, 64'h11}, 4'd3,
                     64'h0000_0000_8000_0040,
                     {64'h44, 64'h33, 64'h22, 64'h11});
        vecs[1] = mk(1'b0, 64'h1234_5678_9ABC_DEFF, '0,
                     {64'h0, 64'h0, 64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001,
                      64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 4'd3,
                     64'h1234_5678_9ABC_DEE0,
                     {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001,
                      64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
        vecs[2] = mk(1'b1, 64'h0000_0000_8000_101F,
                     {64'hA3, 64'hA2, 64'hA1, 64'hA0},
                     {64'h0, 64'h0, 64'hBAD3, 64'hBAD2, 64'hBAD1, 64'hBAD0}, 4'd3,
                     64'h0000_0000_8000_1000,
                     {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001,
                      64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
        vecs[3] = mk(1'b0, 64'h0, '0,
                     {64'h0, 64'h0, 64'h0, 64'h0, 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001}, 4'd1,
                     64'h0,
                     {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001,
                      64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001});
        vecs[4] = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, '0,
                     {64'hE5, 64'hE4, 64'hE3, 64'hE2, 64'hE1, 64'hE0}, 4'd5,
                     64'hFFFF_FFFF_FFFF_FFE0,
                     {64'hE3, 64'hE2, 64'hE1, 64'hE0});
        vecs[5] = mk(1'b1, 64'h0000_0000_0000_0020,
                     {64'hB3, 64'hB2, 64'hB1, 64'hB0},
                     {64'hF5, 64'hF4, 64'hF3, 64'hF2, 64'hF1, 64'hF0}, 4'd5,
                     64'h0000_0000_0000_0020,
                     {64'hE3, 64'hE2, 64'hE1, 64'hE0});

        // Reset state
        reset      = 1'b0;
        creq_valid = 1'b0;
        creq_write = 1'b0;
        creq_addr  = '0;
        creq_wline = '0;
        oresp      = '0;
        #2;
        chk1("rst_oreq_valid", oreq.valid, 1'b0);
        chk1("rst_cresp_valid", cresp_valid, 1'b0);
        chk1("rst_cresp_err", cresp_err, 1'b0);
        chk256("rst_rline", cresp_rline, 256'd0);
        @(posedge clk); #1;
        chk1("rst_edge_oreq_valid", oreq.valid, 1'b0);
        reset = 1'b1;

        // Table-driven transactions; the first is accepted on the first edge after reset
        for (int i = 0; i < 6; i++) begin
            cur_id = i;
            do_txn(vecs[i]);
        end

        // Writeback with the responder ready only on alternate cycles
        cur_id = 10;
        aw[0] = 64'hA0; aw[1] = 64'hA1; aw[2] = 64'hA2; aw[3] = 64'hA3;
        creq_valid = 1'b1;
        creq_write = 1'b1;
        creq_addr  = 64'h0000_0000_8000_1000;
        creq_wline = {aw[3], aw[2], aw[1], aw[0]};
        oresp      = '0;
        @(negedge clk);
        chk1("alt_accept_ready", creq_ready, 1'b1);
        @(posedge clk); #1;
        creq_valid = 1'b0;
        beats = 0;
        dones = 0;
        for (int c = 0; c < 16; c++) begin
            oresp.ready = c[0];
            oresp.last  = c[0] && (beats == 3);
            oresp.data  = 64'hDEAD;
            @(negedge clk);
            if (oreq.valid) begin
                chk64("alt_data", oreq.data, aw[beats]);
                chk64("alt_strobe", 64'(oreq.strobe), 64'hFF);
                if (oresp.ready) beats++;
            end
            if (cresp_valid) dones++;
            @(posedge clk); #1;
        end
        oresp = '0;
        chk64("alt_beats", 64'(beats), 64'd4);
        chk64("alt_done_count", 64'(dones), 64'd1);

        // creq_valid held high through a refill: one acceptance, then the next
        cur_id = 11;
        exp_ready_pat = 7'b1000001;
        exp_cv_pat    = 7'b0100000;
        creq_valid  = 1'b1;
        creq_write  = 1'b0;
        creq_addr   = 64'h100;
        oresp.ready = 1'b1;
        oresp.data  = 64'h77;
        for (int c = 0; c < 7; c++) begin
            oresp.last = (c == 4);
            exp_rdy = {1'b0, exp_ready_pat[c]};
            @(negedge clk);
            chk1("hold_ready", creq_ready, exp_rdy[0]);
            chk1("hold_cresp", cresp_valid, exp_cv_pat[c]);
            @(posedge clk); #1;
        end
        creq_valid = 1'b0;
        oresp.last = 1'b1;
        @(negedge clk);
        chk1("hold_second_burst", oreq.valid, 1'b1);
        chk64("hold_second_addr", oreq.addr, 64'h100);
        @(posedge clk); #1;
        oresp = '0;
        @(negedge clk);
        chk1("hold_second_done", cresp_valid, 1'b1);
        @(posedge clk); #1;

        // Reset during beat 2 of a refill
        cur_id = 12;
        creq_valid = 1'b1;
        creq_write = 1'b0;
        creq_addr  = 64'h4000;
        @(posedge clk); #1;
        creq_valid  = 1'b0;
        oresp.ready = 1'b1;
        oresp.data  = 64'h99;
        @(posedge clk); #1;
        oresp.data  = 64'h98;
        @(posedge clk); #1;
        oresp.data  = 64'h97;
        #2;
        reset = 1'b0;
        #1;
        chk1("midrst_oreq_valid", oreq.valid, 1'b0);
        chk1("midrst_cresp", cresp_valid, 1'b0);
        chk256("midrst_rline", cresp_rline, 256'd0);
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cresp_valid) dones++;
        end
        chk64("midrst_no_done", 64'(dones), 64'd0);
        @(posedge clk); #1;
        oresp = '0;
        reset = 1'b1;
        cur_id = 13;
        do_txn(vecs[0]);

        // Responder never ready
        cur_id = 14;
        creq_valid = 1'b1;
        creq_write = 1'b0;
        creq_addr  = 64'h8000;
        oresp      = '0;
        @(posedge clk); #1;
        creq_valid = 1'b0;
`ifdef CBUS_LINE_MASTER_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk1("to_wait_cresp", cresp_valid, 1'b0);
            chk1("to_wait_oreq", oreq.valid, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1("to_cresp_valid", cresp_valid, 1'b1);
        chk1("to_cresp_err", cresp_err, 1'b1);
        chk1("to_oreq_dropped", oreq.valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("to_back_idle", creq_ready, 1'b1);
        chk1("to_pulse_end", cresp_valid, 1'b0);
        @(posedge clk); #1;
`else
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cresp_valid) dones++;
            @(posedge clk); #1;
        end
        chk64("nto_no_done", 64'(dones), 64'd0);
        @(negedge clk);
        chk1("nto_still_busy", oreq.valid, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cbus_line_master.md
CBUS_LINE_MASTER -- requirements
Module: cbus_line_master

Interface
REQ-001 Parameter LINE_WORDS, default 4, meaning 64-bit words per cache line (power of 2, 1..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit in cycles (used only when the Configuration macro is defined).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous active-low reset.
REQ-005 Port creq_valid  input  1  line request from the cache.
REQ-006 Port creq_ready  output  1  module accepts the request this cycle.
REQ-007 Port creq_write  input  1  1 = line writeback, 0 = line refill.
REQ-008 Port creq_addr  input  64  line base address; low log2(LINE_WORDS)+3 bits are ignored (forced to zero).
REQ-009 Port creq_wline  input  LINE_WORDS*64  writeback data; word i is at bits [64i+63:64i].
REQ-010 Port cresp_valid  output  1  one-cycle completion pulse.
REQ-011 Port cresp_rline  output  LINE_WORDS*64  refill data; stable from the cresp_valid pulse until the next accepted request.
REQ-012 Port cresp_err  output  1  qualifies cresp_valid; 1 = timeout abort.
REQ-013 Port oreq  output  cbus_req_t  CBus request to the responder.
REQ-014 Port oresp  input  cbus_resp_t  CBus response (ready, last, data).

Function
REQ-015 States: IDLE, BURST, DONE; the encoding is free.
REQ-016 IDLE: creq_ready=1; on creq_valid the module latches addr, write, and wline, clears beat to 0, and moves to BURST.
REQ-017 BURST: oreq.valid=1, burst=AXI_BURST_INCR, size=MSIZE8, len=LINE_WORDS-1, is_write=latched write, and addr=latched line base, all held constant for the whole burst.
REQ-018 BURST write: oreq.data=wline word[beat] and oreq.strobe=8'hFF; BURST read: oreq.strobe=0 and oreq.data=0.
REQ-019 A beat completes in each BURST cycle with oresp.ready=1: on a read, oresp.data is stored into rline word[beat]; beat then increments.
REQ-020 The beat counter is log2(LINE_WORDS)+1 bits; once beat reaches LINE_WORDS, further read data is discarded and the write data index holds at LINE_WORDS-1, with no wrap.
REQ-021 A beat with oresp.ready=1 and oresp.last=1 moves BURST to DONE, even if fewer than LINE_WORDS beats have completed; any rline words not written keep their old values.
REQ-022 DONE lasts 1 cycle: cresp_valid=1 and cresp_err=0, then the state returns to IDLE.
REQ-023 In BURST and DONE: creq_ready=0 and creq_valid is ignored; the earliest acceptance of the next request is the cycle after DONE.
REQ-024 Minimum latency from acceptance to cresp_valid is LINE_WORDS+1 cycles.
REQ-025 oresp is ignored outside BURST.

Reset
REQ-026 While reset=0, regardless of clk: state=IDLE, beat=0, oreq.valid=0, cresp_valid=0, cresp_err=0, and rline=0.
REQ-027 Reset asserted mid-burst drops oreq.valid in the same cycle; no cresp_valid is issued for the aborted request.
REQ-028 The first request can be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro CBUS_LINE_MASTER_TIMEOUT_EN.
REQ-030 Macro defined: a watchdog counter is cleared on entry to BURST and on each beat with oresp.ready=1, and increments otherwise; when it reaches TIMEOUT_CYCLES, the state goes to DONE with cresp_err=1 and oreq.valid drops the next cycle.
REQ-031 Macro undefined: no watchdog logic is present, cresp_err is tied to 0, and BURST waits indefinitely.

Verification
REQ-032 Refill with LINE_WORDS=4, addr 0x8000_0040, and a responder that is always ready with data 0x11,0x22,0x33,0x44 (last on beat 3) -> oreq.len=3 and addr constant; cresp_valid in cycle 5 after acceptance; rline={0x44,0x33,0x22,0x11}; err=0.
REQ-033 Writeback of words A0..A3 to addr 0x8000_1000 with ready low on alternate cycles -> oreq.data advances only after a ready beat; strobe=0xFF; 4 data beats; one cresp_valid.
REQ-034 creq_valid held high through a refill -> exactly one acceptance; creq_ready=0 until the cycle after cresp_valid; the second request then starts.
REQ-035 Responder asserts last on beat 1 -> DONE after 2 beats; rline words 2..3 keep their previous values; err=0.
REQ-036 reset=0 during beat 2 of a refill -> oreq.valid=0 immediately; no cresp_valid; after release, a new refill completes normally.
REQ-037 Macro defined, TIMEOUT_CYCLES=8, responder never ready -> cresp_valid=1 with cresp_err=1 8 cycles after BURST entry, then IDLE; macro undefined -> no cresp_valid.
